dm9000a_bus_ctrl: RTL and testbench

//  Timed host-to-DM9000A bus master; successor to the pass-through pin bridge.

---
 rtl/dm9000a_pkg.sv | 38 +++
 rtl/dm9000a_bus_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_dm9000a_bus_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm9000a_pkg.sv
// -----------------------------------------------------------------------------
// dm9000a_pkg
//   Shared definitions for the DM9000A timed bus master.
//   - state_t : controller state encoding (exposed through the debug port)
//   - dbg_t   : debug bundle (current state + data-bus output enable)
//   - DEF_*   : default bus timing and reset-sequence constants
//   - maxOf   : helper used to size the shared down-counter
// -----------------------------------------------------------------------------
package dm9000a_pkg;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    RST_WAIT = 3'd1,
    IDLE     = 3'd2,
    SETUP    = 3'd3,
    STROBE   = 3'd4,
    HOLD     = 3'd5,
    RECOVER  = 3'd6
  } state_t;

  typedef struct packed {
    state_t state;
    logic   busOe;
  } dbg_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_T_SETUP   = 1;
  localparam int DEF_T_PULSE   = 3;
  localparam int DEF_T_HOLD    = 1;
  localparam int DEF_T_RECOVER = 2;
  localparam int DEF_RST_LOW   = 64;
  localparam int DEF_RST_WAIT  = 256;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dm9000a_bus_ctrl.sv
// -----------------------------------------------------------------------------
// dm9000a_bus_ctrl
//   Timed host-to-DM9000A bus master. A single-cycle host request becomes a
//   CS_N/CMD/RD_N/WR_N sequence with programmable setup, pulse, hold and
//   recovery times. After iRST_N release the block first drives the chip's
//   hardware reset low for RST_LOW cycles, then waits RST_WAIT cycles before
//   accepting accesses.
//
//   Host handshake: iREQ is sampled only on an edge where oBUSY=0; on that edge
//   iWE/iCMD/iDATA are latched and oBUSY rises the following cycle. A request
//   made while oBUSY=1 is dropped. oACK pulses for one cycle when the access
//   completes; for reads oDATA updates together with that pulse.
//
// Ports
//   iCLK, iRST_N           clock, asynchronous active-low reset
//   iREQ/iWE/iCMD/iDATA    host request (write flag, CMD level, write data)
//   oDATA/oACK/oBUSY       read data, completion pulse, busy flag
//   oINT                   chip interrupt towards the host
//   ENET_*                 DM9000A pins (data bus is tri-stated when idle)
//   oDbg                   current state and data-bus output enable
//
// Configuration
//   DM9000A_INT_SYNC_EN    when defined, ENET_INT passes a 2-flop synchroniser
//                          (oINT lags two cycles); otherwise oINT = ENET_INT.
// -----------------------------------------------------------------------------
module dm9000a_bus_ctrl
  import dm9000a_pkg::state_t, dm9000a_pkg::dbg_t, dm9000a_pkg::maxOf,
         dm9000a_pkg::RST_HOLD, dm9000a_pkg::IDLE, dm9000a_pkg::SETUP,
         dm9000a_pkg::STROBE, dm9000a_pkg::HOLD, dm9000a_pkg::RECOVER,
         dm9000a_pkg::DEF_DATA_W, dm9000a_pkg::DEF_T_SETUP,
         dm9000a_pkg::DEF_T_PULSE, dm9000a_pkg::DEF_T_HOLD,
         dm9000a_pkg::DEF_T_RECOVER, dm9000a_pkg::DEF_RST_LOW,
         dm9000a_pkg::DEF_RST_WAIT;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_PULSE   = DEF_T_PULSE,
  parameter int T_HOLD    = DEF_T_HOLD,
  parameter int T_RECOVER = DEF_T_RECOVER,
  parameter int RST_LOW   = DEF_RST_LOW,
  parameter int RST_WAIT  = DEF_RST_WAIT
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iREQ,
  input  logic              iWE,
  input  logic              iCMD,
  input  logic [DATA_W-1:0] iDATA,
  output logic [DATA_W-1:0] oDATA,
  output logic              oACK,
  output logic              oBUSY,
  output logic              oINT,
  inout  wire  [DATA_W-1:0] ENET_DATA,
  output logic              ENET_CMD,
  output logic              ENET_RD_N,
  output logic              ENET_WR_N,
  output logic              ENET_CS_N,
  output logic              ENET_RST_N,
  input  logic              ENET_INT,
  output dbg_t              oDbg
);

  localparam int MAX_P = maxOf(maxOf(maxOf(T_SETUP, T_PULSE), maxOf(T_HOLD, T_RECOVER)),
                               maxOf(RST_LOW, RST_WAIT));
  localparam int CNT_W = $clog2(MAX_P) + 1;

  state_t              state, nextState;
  logic [CNT_W-1:0]    cnt, nextCnt;
  logic                accept;
  logic                weL, cmdL;
  logic [DATA_W-1:0]   dataL, rdCap;
  logic                weN, cmdN;
  logic [DATA_W-1:0]   dataN;
  logic                inAccN;
  logic                busOe;
  logic                cntDone;

  assign cntDone = (cnt == '0);

  // Every timed state runs for (load value + 1) cycles; the counter is
  // reloaded with the next state's duration minus one on each transition.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    accept    = 1'b0;
    unique case (state)
      RST_HOLD: begin
        if (cntDone) begin
          nextState = dm9000a_pkg::RST_WAIT;
          nextCnt   = CNT_W'(RST_WAIT - 1);
        end else begin
          nextCnt = cnt - CNT_W'(1);
        end
      end
      dm9000a_pkg::RST_WAIT: begin
        if (cntDone) begin
          nextState = IDLE;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt - CNT_W'(1);
        end
      end
      IDLE: begin
        if (iREQ) begin
          accept    = 1'b1;
          nextState = SETUP;
          nextCnt   = CNT_W'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (cntDone) begin
          nextState = STROBE;
          nextCnt   = CNT_W'(T_PULSE - 1);
        end else begin
          nextCnt = cnt - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cntDone) begin
          nextState = HOLD;
          nextCnt   = CNT_W'(T_HOLD - 1);
        end else begin
          nextCnt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cntDone) begin
          nextState = RECOVER;
          nextCnt   = CNT_W'(T_RECOVER - 1);
        end else begin
          nextCnt = cnt - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cntDone) begin
          nextState = IDLE;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt - CNT_W'(1);
        end
      end
      default: begin
        nextState = RST_HOLD;
        nextCnt   = CNT_W'(RST_LOW - 1);
      end
    endcase
  end

  // Request fields as they will be after this edge, so the pin registers can
  // already reflect a request accepted on the same edge.
  assign weN    = accept ? iWE   : weL;
  assign cmdN   = accept ? iCMD  : cmdL;
  assign dataN  = accept ? iDATA : dataL;
  assign inAccN = (nextState == SETUP) || (nextState == STROBE) || (nextState == HOLD);

  // Pins are registered from the next-state decode so they change exactly on
  // the state-entry edge and never glitch.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= RST_HOLD;
      cnt        <= CNT_W'(RST_LOW - 1);
      weL        <= 1'b0;
      cmdL       <= 1'b0;
      dataL      <= '0;
      rdCap      <= '0;
      ENET_CS_N  <= 1'b1;
      ENET_RD_N  <= 1'b1;
      ENET_WR_N  <= 1'b1;
      ENET_CMD   <= 1'b0;
      ENET_RST_N <= 1'b0;
      busOe      <= 1'b0;
      oACK       <= 1'b0;
      oBUSY      <= 1'b1;
      oDATA      <= '0;
    end else begin
      state      <= nextState;
      cnt        <= nextCnt;
      weL        <= weN;
      cmdL       <= cmdN;
      dataL      <= dataN;
      ENET_CS_N  <= !inAccN;
      ENET_CMD   <= inAccN && cmdN;
      ENET_WR_N  <= !((nextState == STROBE) && weN);
      ENET_RD_N  <= !((nextState == STROBE) && !weN);
      busOe      <= inAccN && weN;
      ENET_RST_N <= (nextState != RST_HOLD);
      oBUSY      <= (nextState != IDLE);
      oACK       <= (state == HOLD) && (nextState == RECOVER);
      // Sample on the edge that ends the strobe: RD_N is still low here.
      if ((state == STROBE) && (nextState == HOLD) && !weL) begin
        rdCap <= ENET_DATA;
      end
      if ((state == HOLD) && (nextState == RECOVER) && !weL) begin
        oDATA <= rdCap;
      end
    end
  end

  assign ENET_DATA = busOe ? dataL : {DATA_W{1'bz}};

  assign oDbg.state = state;
  assign oDbg.busOe = busOe;

`ifdef DM9000A_INT_SYNC_EN
  logic intMeta, intSync;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      intMeta <= 1'b0;
      intSync <= 1'b0;
    end else begin
      intMeta <= ENET_INT;
      intSync <= intMeta;
    end
  end

  assign oINT = intSync;
`else
  assign oINT = ENET_INT;
`endif

endmodule

// File: tb/tb_dm9000a_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm9000a_bus_ctrl
//   Bench for dm9000a_bus_ctrl with RST_LOW=4, RST_WAIT=8 and default bus
//   timing. A timeline model (cycles since reset release, cycle index inside
//   the current access) predicts every pin each cycle; directed scenarios pin
//   the model with hand-computed cycle counts and values.
// -----------------------------------------------------------------------------
module tb_dm9000a_bus_ctrl;
  import dm9000a_pkg::*;

  localparam int TS = 1, TP = 3, TH = 1, TR = 2, RL = 4, RW = 8;
  localparam int ACC_END = TS + TP + TH;   // last cycle with CS_N low
  localparam int ACK_AT  = ACC_END + 1;    // access cycle carrying oACK
  localparam int ACC_LEN = ACC_END + TR;   // last cycle before IDLE
  localparam logic [15:0] CHIP_RD = 16'hA55A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0, cmd = 1'b0, enetInt = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] odata;
  logic        ack, busy, oint, enetCmd, rdN, wrN, csN, enetRstN;
  wire  [15:0] enetData;
  dbg_t        dbg;

  // Chip model: drives read data whenever it is selected and read-strobed.
  assign enetData = (!rdN && !csN) ? CHIP_RD : 16'hzzzz;

  dm9000a_bus_ctrl #(
    .DATA_W(16), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
    .T_RECOVER(TR), .RST_LOW(RL), .RST_WAIT(RW)
  ) dut (
    .iCLK(clk), .iRST_N(rstN), .iREQ(req), .iWE(we), .iCMD(cmd),
    .iDATA(data), .oDATA(odata), .oACK(ack), .oBUSY(busy), .oINT(oint),
    .ENET_DATA(enetData), .ENET_CMD(enetCmd), .ENET_RD_N(rdN),
    .ENET_WR_N(wrN), .ENET_CS_N(csN), .ENET_RST_N(enetRstN),
    .ENET_INT(enetInt), .oDbg(dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- timeline model ----------------
  int          mRst = 0;     // edges since reset release (saturating)
  int          mK   = 0;     // 0 = no access, else cycle index within access
  logic        mWe = 1'b0, mCmd = 1'b0;
  logic [15:0] mData = '0, mOData = '0;
  logic [15:0] exp_q[$];     // read data expected to appear on oDATA
  bit          ready;

  initial forever begin
    @(posedge clk or negedge rstN);
    if (!rstN) begin
      mRst = 0;
      mK = 0;
      mOData = '0;
      exp_q.delete();
    end else begin
      ready = (mRst >= RL + RW) && (mK == 0);
      if (mRst < RL + RW) mRst++;
      if (mK != 0) begin
        mK++;
        if (mK > ACC_LEN) mK = 0;
      end else if (ready && req) begin
        mK = 1;
        mWe = we;
        mCmd = cmd;
        mData = data;
        if (!we) exp_q.push_back(CHIP_RD);
      end
      if (mK == ACK_AT && !mWe && exp_q.size() > 0) mOData = exp_q.pop_front();
    end
  end

  // ---------------- per-cycle compare ----------------
  bit inAcc, strb;
  initial forever begin
    @(negedge clk);
    inAcc = (mK >= 1) && (mK <= ACC_END);
    strb  = (mK > TS) && (mK <= TS + TP);
    check("cyc_csN",   csN,       !inAcc);
    check("cyc_wrN",   wrN,       !(strb && mWe));
    check("cyc_rdN",   rdN,       !(strb && !mWe));
    check("cyc_cmd",   enetCmd,   inAcc && mCmd);
    check("cyc_oe",    dbg.busOe, inAcc && mWe);
    check("cyc_ack",   ack,       mK == ACK_AT);
    check("cyc_busy",  busy,      !((mRst >= RL + RW) && (mK == 0)));
    check("cyc_rstN",  enetRstN,  mRst >= RL);
    check("cyc_odata", odata,     mOData);
    if (inAcc && mWe) check("cyc_wdata", enetData, mData);
    if (strb && !mWe) check("cyc_rdata", enetData, CHIP_RD);
  end

  // ---------------- driver tasks ----------------
  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  // Issues one request at a negedge with oBUSY=0 and observes eight cycles.
  task automatic runAccess(input logic w, input logic c, input logic [15:0] d,
                           output int csLow, output int strFirst, output int strLast,
                           output int ackAt, output logic [15:0] busVal,
                           output int oeCycles, output logic cmdSeen);
    csLow = 0; strFirst = 0; strLast = 0; ackAt = 0; busVal = '0;
    oeCycles = 0; cmdSeen = 1'b0;
    req = 1'b1; we = w; cmd = c; data = d;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) req = 1'b0;
      if (!csN) begin
        csLow++;
        cmdSeen = enetCmd;
      end
      if ((w ? wrN : rdN) == 1'b0) begin
        if (strFirst == 0) strFirst = i;
        strLast = i;
        busVal = enetData;
      end
      if (ack) ackAt = i;
      if (dbg.busOe) oeCycles++;
    end
  endtask

  // ---------------- directed scenarios ----------------
  int n, relCycle, csLow, strFirst, strLast, ackAt, oeCycles, ackCnt, lowTotal;
  int falls[$];
  logic [15:0] busVal;
  logic cmdSeen, prevCs;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", dbg.state, RST_HOLD);
    check("reset_busy", busy, 1'b1);
    check("reset_odata", odata, 16'h0000);
    check("reset_enet_rst", enetRstN, 1'b0);

    // Reset release: chip reset low 4 cycles, oBUSY falls 12 edges later.
    rstN = 1'b1;
    relCycle = cyc;
    n = 0;
    while (enetRstN == 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rst_low_cycles", n, 4);
    waitIdle("rst_wait_idle");
    check("busy_fall_edges", cyc - relCycle, 12);
    check("idle_state", dbg.state, IDLE);

    // Index write.
    runAccess(1'b1, 1'b0, 16'h0005, csLow, strFirst, strLast, ackAt, busVal, oeCycles, cmdSeen);
    check("wr_cs_low", csLow, 5);
    check("wr_strobe_first", strFirst, 2);
    check("wr_strobe_last", strLast, 4);
    check("wr_ack_cycle", ackAt, 6);
    check("wr_bus", busVal, 16'h0005);
    check("wr_oe_cycles", oeCycles, 5);
    check("wr_cmd", cmdSeen, 1'b0);
    check("wr_odata_kept", odata, 16'h0000);
    waitIdle("wr_idle");

    // Data read.
    runAccess(1'b0, 1'b1, 16'hFFFF, csLow, strFirst, strLast, ackAt, busVal, oeCycles, cmdSeen);
    check("rd_cs_low", csLow, 5);
    check("rd_strobe_len", strLast - strFirst + 1, 3);
    check("rd_ack_cycle", ackAt, 6);
    check("rd_bus", busVal, CHIP_RD);
    check("rd_oe_cycles", oeCycles, 0);
    check("rd_cmd", cmdSeen, 1'b1);
    check("rd_odata", odata, 16'hA55A);
    waitIdle("rd_idle");

    // Data write leaves oDATA untouched.
    runAccess(1'b1, 1'b1, 16'h1234, csLow, strFirst, strLast, ackAt, busVal, oeCycles, cmdSeen);
    check("wr2_bus", busVal, 16'h1234);
    check("wr2_cmd", cmdSeen, 1'b1);
    check("wr2_odata_kept", odata, 16'hA55A);
    waitIdle("wr2_idle");

    // Back-to-back: iREQ held high.
    falls.delete();
    lowTotal = 0;
    prevCs = csN;
    req = 1'b1; we = 1'b1; cmd = 1'b1; data = 16'h00C3;
    n = 0;
    while (falls.size() < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (prevCs && !csN) falls.push_back(cyc);
      if (!csN && falls.size() > 0 && falls.size() < 3) lowTotal++;
      prevCs = csN;
    end
    req = 1'b0;
    check("b2b_starts", falls.size(), 3);
    if (falls.size() == 3) begin
      check("b2b_gap1", falls[1] - falls[0], 8);
      check("b2b_gap2", falls[2] - falls[1], 8);
    end
    check("b2b_cs_low_total", lowTotal, 10);
    waitIdle("b2b_idle");

    // Reset during STROBE of a write.
    req = 1'b1; we = 1'b1; cmd = 1'b0; data = 16'h5A5A;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("abort_pre_wrN", wrN, 1'b0);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    check("abort_wrN", wrN, 1'b1);
    check("abort_csN", csN, 1'b1);
    check("abort_oe", dbg.busOe, 1'b0);
    check("abort_enet_rst", enetRstN, 1'b0);
    check("abort_odata", odata, 16'h0000);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    ackCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) ackCnt++;
    end
    check("abort_no_ack", ackCnt, 0);
    waitIdle("abort_idle");

    runAccess(1'b0, 1'b0, 16'h0000, csLow, strFirst, strLast, ackAt, busVal, oeCycles, cmdSeen);
    check("post_abort_ack", ackAt, 6);
    check("post_abort_odata", odata, 16'hA55A);
    waitIdle("post_abort_idle");

    // Interrupt path.
    @(negedge clk);
    enetInt = 1'b1;
`ifdef DM9000A_INT_SYNC_EN
    #1 check("int_edge0", oint, 1'b0);
    @(posedge clk);
    #1 check("int_edge1", oint, 1'b0);
    @(posedge clk);
    #1 check("int_edge2", oint, 1'b1);
`else
    #1 check("int_comb", oint, 1'b1);
`endif
    @(negedge clk);
    enetInt = 1'b0;
    repeat (3) @(negedge clk);
    check("int_low", oint, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
